alu16_op_sequencer: RTL and testbench
=====================================

Name: alu16_op_sequencer

Overview:
Upstream control stage for the 16-bit ripple ALU built from the bit-slice cells. It accepts one operation per valid/ready transaction, registers the operands and drives every slice's A/B/C1/C2/C3/P/CIN lines from flops. It holds those lines for a fixed settle window, then captures the slice outputs and final carry into a result register with flags. The result is presented downstream through a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width (number of slices driven)
SETTLE_CYCLES, 4, cycles the slice inputs are held stable before capture; legal range 1..15

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
op_valid  in  1  operation request
op_ready  out  1  sequencer can accept
op_code  in  3  {C1,C2,C3} operation select
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
alu_a  out  WIDTH  to slice A inputs
alu_b  out  WIDTH  to slice B inputs
alu_c1, alu_c2, alu_c3  out  1 each  slice function select, broadcast
alu_p  out  1  slice B-invert (subtract) control
alu_cin  out  1  carry into slice 0
alu_o  in  WIDTH  slice O outputs
alu_cout  in  1  COUT of the MSB slice
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  captured result
res_cout  out  1  captured carry (arithmetic ops only)
res_zero  out  1  res_data == 0

Behaviour:
- Opcode map {C1,C2,C3}: 000 NOR, 001 NAND, 010 OR, 011 AND, 100 XOR, 101 XNOR, 110 ADD, 111 SUB. All 8 codes are legal.
- Controls: alu_c1..c3 = op_code bits. alu_p = alu_cin = 1 for SUB only, 0 otherwise.
- States: IDLE, SETTLE, HOLD.
- IDLE: op_ready=1.
  - On op_valid & op_ready at an edge: register op_a, op_b, op_code, and derived P/CIN onto the alu_* outputs.
  - Load cnt = SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: op_ready=0; alu_* held constant.
  - At each edge with cnt != 0: decrement cnt.
  - At the edge with cnt == 0: capture res_data = alu_o, res_cout = alu_cout for ADD/SUB (forced 0 for logic ops), res_zero = (alu_o == 0). Set res_valid=1 and go to HOLD.
- Latency: accept at edge k; res_valid is high after edge k+SETTLE_CYCLES.
- HOLD: res_valid=1; res_* stable; op_ready=0; op_valid ignored.
  - At the edge with res_ready=1: res_valid←0, go to IDLE.
  - op_ready rises after that edge; no same-cycle pass-through.
- Throughput: one op per SETTLE_CYCLES+2 cycles minimum.
- alu_* outputs keep their last values in IDLE and HOLD; they change only on accept.
- Reset (any state, asynchronous): state=IDLE, op_ready=1, res_valid=0, res_data=0, res_cout=0, res_zero=0, all alu_* = 0, cnt=0.
  - Reset mid-SETTLE or mid-HOLD discards the operation with no result emitted.
- Counter width is 4 bits; SETTLE_CYCLES outside 1..15 is a configuration error, flagged by a simulation-only check.

Optional Feature:
ALU_OVF_EN
- Defined: adds output port res_ovf (1 bit, reset 0), captured together with res_data.
  - ADD: res_ovf = (a[MSB]==b[MSB]) & (o[MSB]!=a[MSB]).
  - SUB: res_ovf = (a[MSB]!=b[MSB]) & (o[MSB]!=a[MSB]).
  - Logic ops: res_ovf = 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert RST asynchronously with no clock edge → all outputs at reset values; after release op_ready=1, res_valid=0.
- ADD (bench drives alu_o/alu_cout from a behavioural 16-slice model): 0x7FFF + 0x0001 accepted at edge k → alu_c1..c3=110, alu_p=0, alu_cin=0. res_valid high after edge k+4 with res_data=0x8000, res_cout=0, res_zero=0; res_ovf=1 when ALU_OVF_EN is defined.
- SUB 0x0005 - 0x0005 → alu_p=1, alu_cin=1, res_data=0x0000, res_cout=1, res_zero=1, res_ovf=0.
- Logic ops:
  - NAND 0xFFFF,0xFFFF → res_data=0x0000, res_cout=0 even if the model drives alu_cout=1.
  - XNOR 0x00FF,0x0F0F → 0xF00F.
  - NOR 0x0000,0x0000 → 0xFFFF.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid, pulsing op_valid → res_* stable, op_ready=0, no accept. Then res_ready=1 for one cycle → res_valid=0 and op_ready=1 after that edge.
- Reset mid-op: assert RST two cycles into SETTLE → IDLE immediately. After release a new ADD 0x0001+0x0001 yields 0x0002 with correct latency and no stale result.

Source files
------------

// File: rtl/alu16_op_sequencer_if.sv
// Operation/result handshakes and slice bus for alu16_op_sequencer.
// res_ovf exists only when ALU_OVF_EN is defined.
interface alu16_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_c1;
    logic             alu_c2;
    logic             alu_c3;
    logic             alu_p;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_o;
    logic             alu_cout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_zero;
`ifdef ALU_OVF_EN
    logic             res_ovf;
`endif

    // Environment side: issues operations, models the slices, consumes results
    modport master (
        output op_valid, op_code, op_a, op_b, alu_o, alu_cout, res_ready,
        input  op_ready, alu_a, alu_b, alu_c1, alu_c2, alu_c3, alu_p, alu_cin,
`ifdef ALU_OVF_EN
        input  res_ovf,
`endif
        input  res_valid, res_data, res_cout, res_zero
    );

    // Sequencer side
    modport slave (
        input  op_valid, op_code, op_a, op_b, alu_o, alu_cout, res_ready,
        output op_ready, alu_a, alu_b, alu_c1, alu_c2, alu_c3, alu_p, alu_cin,
`ifdef ALU_OVF_EN
        output res_ovf,
`endif
        output res_valid, res_data, res_cout, res_zero
    );
endinterface

// File: rtl/alu16_op_sequencer.sv
// Control stage for the 16-slice ripple ALU: accept op, hold slice inputs for a
// settle window, capture result with flags. Optional ALU_OVF_EN adds res_ovf.
module alu16_op_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    alu16_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu16_op_sequencer: SETTLE_CYCLES must be within 1..15");
    end

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             op_ready_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [2:0]       alu_ctl_r;
    logic             alu_sub_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_cout_r;
    logic             res_zero_r;
`ifdef ALU_OVF_EN
    logic             res_ovf_r;
`endif

    function automatic logic is_sub(input logic [2:0] code);
        return code == 3'b111;
    endfunction

    // ADD and SUB share the 11x prefix; only they carry a meaningful COUT
    function automatic logic is_arith(input logic [2:0] code);
        return code[2] & code[1];
    endfunction

    // Signed overflow: operand signs (after the SUB inversion) agree but result sign differs
    function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic o_msb);
        return ((a_msb ^ b_msb) == sub) & (o_msb != a_msb);
    endfunction

    // Sequencer state, slice drive registers and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            op_ready_r  <= 1'b1;
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_ctl_r   <= 3'b000;
            alu_sub_r   <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_cout_r  <= 1'b0;
            res_zero_r  <= 1'b0;
`ifdef ALU_OVF_EN
            res_ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.op_valid && op_ready_r) begin
                        alu_a_r    <= bus.op_a;
                        alu_b_r    <= bus.op_b;
                        alu_ctl_r  <= bus.op_code;
                        alu_sub_r  <= is_sub(bus.op_code);
                        cnt_r      <= 4'(SETTLE_CYCLES - 1);
                        op_ready_r <= 1'b0;
                        state_r    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        res_data_r  <= bus.alu_o;
                        res_cout_r  <= is_arith(alu_ctl_r) & bus.alu_cout;
                        res_zero_r  <= (bus.alu_o == {WIDTH{1'b0}});
`ifdef ALU_OVF_EN
                        res_ovf_r   <= is_arith(alu_ctl_r) &
                                       ovf_calc(alu_sub_r, alu_a_r[WIDTH-1],
                                                alu_b_r[WIDTH-1], bus.alu_o[WIDTH-1]);
`endif
                        res_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        op_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    op_ready_r  <= 1'b1;
                    cnt_r       <= 4'd0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready  = op_ready_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_c1    = alu_ctl_r[2];
    assign bus.alu_c2    = alu_ctl_r[1];
    assign bus.alu_c3    = alu_ctl_r[0];
    assign bus.alu_p     = alu_sub_r;
    assign bus.alu_cin   = alu_sub_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_cout  = res_cout_r;
    assign bus.res_zero  = res_zero_r;
`ifdef ALU_OVF_EN
    assign bus.res_ovf   = res_ovf_r;
`endif
endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Scoreboard bench for alu16_op_sequencer with a behavioural 16-slice ALU stand-in.
module tb_alu16_op_sequencer;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 4;

    typedef struct {
        logic [2:0]  code;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        cout;
        logic        zero;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu16_op_sequencer_if #(.WIDTH(WIDTH)) bus ();
    alu16_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vecs = 0;
    int   miss = 0;
    int   cyc  = 0;
    exp_t sb[$];

    int   rdy_mode   = 0;     // 0: always ready, 1: random, 2: manual_rdy
    logic manual_rdy = 1'b0;
    int   junk_mode  = 0;     // 0: random junk carry on logic ops, 1: forced 1
    logic junk_cout  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slice stand-in: whole-word arithmetic on whatever the DUT drives
    logic [WIDTH-1:0] beff_s;
    logic [WIDTH:0]   sum_s;
    always_comb begin
        beff_s       = bus.alu_p ? ~bus.alu_b : bus.alu_b;
        sum_s        = {1'b0, bus.alu_a} + {1'b0, beff_s} + {{WIDTH{1'b0}}, bus.alu_cin};
        bus.alu_cout = junk_cout;
        case ({bus.alu_c1, bus.alu_c2, bus.alu_c3})
            3'd0: bus.alu_o = ~(bus.alu_a | bus.alu_b);
            3'd1: bus.alu_o = ~(bus.alu_a & bus.alu_b);
            3'd2: bus.alu_o = bus.alu_a | bus.alu_b;
            3'd3: bus.alu_o = bus.alu_a & bus.alu_b;
            3'd4: bus.alu_o = bus.alu_a ^ bus.alu_b;
            3'd5: bus.alu_o = ~(bus.alu_a ^ bus.alu_b);
            default: begin
                bus.alu_o    = sum_s[WIDTH-1:0];
                bus.alu_cout = sum_s[WIDTH];
            end
        endcase
    end

    initial begin : env_drive
        forever begin
            @(negedge clk);
            junk_cout = (junk_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rdy_mode == 0)      bus.res_ready = 1'b1;
            else if (rdy_mode == 1) bus.res_ready = 1'($urandom_range(0, 1));
            else                    bus.res_ready = manual_rdy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode meaning
    function automatic exp_t model(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int ua, ub, sa, sbv, s;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sbv = int'($signed(b));
        e.code = code; e.a = a; e.b = b; e.cout = 1'b0; e.ovf = 1'b0; e.due = 0;
        case (code)
            3'd0: e.data = ~(a | b);
            3'd1: e.data = ~(a & b);
            3'd2: e.data = a | b;
            3'd3: e.data = a & b;
            3'd4: e.data = a ^ b;
            3'd5: e.data = ~(a ^ b);
            3'd6: begin
                e.data = 16'(ua + ub);
                e.cout = (ua + ub) > 65535;
                s = sa + sbv;
                e.ovf = (s > 32767) || (s < -32768);
            end
            default: begin
                e.data = 16'(ua - ub);
                e.cout = (ua >= ub);
                s = sa - sbv;
                e.ovf = (s > 32767) || (s < -32768);
            end
        endcase
        e.zero = (e.data == 16'h0000);
        return e;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_op_ready"}, bus.op_ready, 1);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_res_cout"}, bus.res_cout, 0);
        chk({tag, "_res_zero"}, bus.res_zero, 0);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_alu_b"}, bus.alu_b, 0);
        chk({tag, "_alu_ctl"}, {bus.alu_c1, bus.alu_c2, bus.alu_c3, bus.alu_p, bus.alu_cin}, 0);
`ifdef ALU_OVF_EN
        chk({tag, "_res_ovf"}, bus.res_ovf, 0);
`endif
    endtask

    task automatic issue(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = b;
        n = 0;
        while (!bus.op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 200, 1);
        if (n < 200) begin
            e = model(code, a, b);
            e.due = cyc + 1 + SETTLE;
            sb.push_back(e);
            @(negedge clk);
            bus.op_valid = 1'b0;
            bus.op_a = 16'($urandom); bus.op_b = 16'($urandom); bus.op_code = 3'($urandom);
            chk("acc_alu_a", bus.alu_a, a);
            chk("acc_alu_b", bus.alu_b, b);
            chk("acc_alu_c", {bus.alu_c1, bus.alu_c2, bus.alu_c3}, code);
            chk("acc_alu_p", bus.alu_p, code == 3'd7);
            chk("acc_alu_cin", bus.alu_cin, code == 3'd7);
            chk("acc_op_ready", bus.op_ready, 0);
        end else begin
            bus.op_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin : monitor
        logic prev_valid, prev_hs;
        exp_t cur;
        prev_valid = 1'b0; prev_hs = 1'b0;
        cur = model(3'd0, 16'h0, 16'h0);
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0; prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("hs_res_valid", bus.res_valid, 0);
                    chk("hs_op_ready", bus.op_ready, 1);
                end
                if (bus.res_valid) begin
                    chk("hold_op_ready", bus.op_ready, 0);
                    if (!prev_valid) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result", sb.size(), 1);
                        end else begin
                            cur = sb.pop_front();
                            chk("res_data", bus.res_data, cur.data);
                            chk("res_cout", bus.res_cout, cur.cout);
                            chk("res_zero", bus.res_zero, cur.zero);
`ifdef ALU_OVF_EN
                            chk("res_ovf", bus.res_ovf, cur.ovf);
`endif
                            chk("latency", cyc, cur.due);
                            chk("held_alu_a", bus.alu_a, cur.a);
                            chk("held_alu_b", bus.alu_b, cur.b);
                            chk("held_alu_c", {bus.alu_c1, bus.alu_c2, bus.alu_c3}, cur.code);
                        end
                    end else begin
                        chk("stable_data", bus.res_data, cur.data);
                        chk("stable_cout", bus.res_cout, cur.cout);
                        chk("stable_zero", bus.res_zero, cur.zero);
                    end
                end
                prev_valid = bus.res_valid;
                prev_hs    = bus.res_valid & bus.res_ready;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic [15:0] ra, rb;
        bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_a = 16'h0; bus.op_b = 16'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_op_ready", bus.op_ready, 1);
        chk("post_rst_res_valid", bus.res_valid, 0);

        // Directed operations
        issue(3'd6, 16'h7FFF, 16'h0001);
        issue(3'd7, 16'h0005, 16'h0005);
        drain();
        junk_mode = 1;
        issue(3'd1, 16'hFFFF, 16'hFFFF);
        drain();
        junk_mode = 0;
        issue(3'd5, 16'h00FF, 16'h0F0F);
        issue(3'd0, 16'h0000, 16'h0000);
        drain();

        // Backpressure with op_valid pulses while a result is held
        rdy_mode = 2; manual_rdy = 1'b0;
        issue(3'd6, 16'h1234, 16'h4321);
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_wait", n < 50, 1);
        repeat (10) begin
            @(negedge clk);
            bus.op_valid = ~bus.op_valid;
            bus.op_code = 3'd3; bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
            chk("bp_op_ready", bus.op_ready, 0);
            chk("bp_alu_a", bus.alu_a, 16'h1234);
            chk("bp_res_valid", bus.res_valid, 1);
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        manual_rdy = 1'b1;
        @(posedge clk); #1;
        manual_rdy = 1'b0;
        drain();

        // Reset two cycles into SETTLE discards the op
        rdy_mode = 0;
        issue(3'd6, 16'hAAAA, 16'h1111);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset("mid_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(3'd6, 16'h0001, 16'h0001);
        drain();

        // Randomized traffic with random consumer backpressure
        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 4))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                2: ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 5) == 0) ? ra : 16'($urandom);
            issue(3'($urandom), ra, rb);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
